// File: rtl/l1_dcache.sv
// 2-way set-associative, write-back, write-allocate L1 data cache.
// Serves the LSQ word interface and refills/evicts whole lines over pmem.
module l1_dcache #(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 3,
    parameter int S_TAG    = 32 - S_OFFSET - S_INDEX,
    parameter int S_LINE   = 8 * (1 << S_OFFSET)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_read,
    input  logic              data_write,
    input  logic [3:0]        data_mbe,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_resp,
    output logic [31:0]       data_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [S_LINE-1:0] pmem_wdata,
    input  logic [S_LINE-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam int NSETS = 1 << S_INDEX;
    localparam int W_SEL = S_OFFSET - 2;

    typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, FILL} state_t;

    state_t state_q, state_d;

    logic [NSETS-1:0]  valid_q [2];
    logic [NSETS-1:0]  dirty_q [2];
    logic [NSETS-1:0]  lru_q;
    logic [S_TAG-1:0]  tag_q   [2][NSETS];
    logic [S_LINE-1:0] line_q  [2][NSETS];
    logic              victim_q;

    logic [S_INDEX-1:0] idx;
    logic [S_TAG-1:0]   tag;
    logic [W_SEL-1:0]   wsel;
    logic               hit0, hit1, hit, hit_way, victim, is_write;
    logic [31:0]        hit_word, merged_word;
    logic               unused_addr_lsbs;

    assign idx      = data_addr[S_OFFSET +: S_INDEX];
    assign tag      = data_addr[31 -: S_TAG];
    assign wsel     = data_addr[S_OFFSET-1:2];
    assign is_write = data_write & ~data_read;
    assign unused_addr_lsbs = ^data_addr[1:0];

    assign hit0     = valid_q[0][idx] && (tag_q[0][idx] == tag);
    assign hit1     = valid_q[1][idx] && (tag_q[1][idx] == tag);
    assign hit      = hit0 | hit1;
    assign hit_way  = ~hit0;
    assign hit_word = line_q[hit_way][idx][{wsel, 5'b0} +: 32];

    // Invalid ways are filled before anything is evicted; otherwise the LRU bit decides.
    assign victim = !valid_q[0][idx] ? 1'b0 :
                    !valid_q[1][idx] ? 1'b1 : lru_q[idx];

    always_comb begin
        merged_word = hit_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (data_mbe[i]) merged_word[8*i +: 8] = data_wdata[8*i +: 8];
        end
    end

    always_comb begin
        state_d      = state_q;
        data_resp    = 1'b0;
        data_rdata   = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        unique case (state_q)
            IDLE: begin
                if (data_read || data_write) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    data_resp = 1'b1;
                    if (!is_write) data_rdata = hit_word;
                    state_d = IDLE;
                end else if (valid_q[victim][idx] && dirty_q[victim][idx]) begin
                    state_d = WRITEBACK;
                end else begin
                    state_d = FILL;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[victim_q][idx], idx, {S_OFFSET{1'b0}}};
                pmem_wdata   = line_q[victim_q][idx];
                if (pmem_resp) state_d = FILL;
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {tag, idx, {S_OFFSET{1'b0}}};
                if (pmem_resp) state_d = LOOKUP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            victim_q   <= 1'b0;
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            dirty_q[0] <= '0;
            dirty_q[1] <= '0;
            lru_q      <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                LOOKUP: begin
                    if (hit) begin
                        lru_q[idx] <= ~hit_way;
                        if (is_write) dirty_q[hit_way][idx] <= 1'b1;
                    end else begin
                        victim_q <= victim;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) dirty_q[victim_q][idx] <= 1'b0;
                end
                FILL: begin
                    if (pmem_resp) begin
                        tag_q[victim_q][idx]   <= tag;
                        valid_q[victim_q][idx] <= 1'b1;
                        dirty_q[victim_q][idx] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Line storage carries no reset; only the valid bits qualify its contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == FILL && pmem_resp)
                line_q[victim_q][idx] <= pmem_rdata;
            else if (state_q == LOOKUP && hit && is_write)
                line_q[hit_way][idx][{wsel, 5'b0} +: 32] <= merged_word;
        end
    end

    a_no_rw_both: assert property (@(posedge clk) disable iff (rst)
        !(data_read && data_write));

    a_req_stable_in_miss: assert property (@(posedge clk) disable iff (rst)
        (state_q == WRITEBACK || state_q == FILL) |->
        ($stable(data_addr) && $stable(data_read) && $stable(data_write) &&
         $stable(data_mbe) && $stable(data_wdata)));

endmodule

// File: doc/l1_dcache.md
Name: l1_dcache

Overview:
- 2-way set-associative, write-back, write-allocate L1 data cache.
- Acts as the responder on the load/store queue's 32-bit d-cache interface (data_read/data_write/data_mbe/data_addr/data_wdata -> data_resp/data_rdata).
- Downstream, issues 256-bit line reads and writebacks to the memory arbiter over the pmem interface.
- Sits between the execute stage's load/store queue and the arbiter.

Parameters:
- S_OFFSET, 5, byte-offset bits; line = 2^S_OFFSET bytes (32 B, 8 words).
- S_INDEX, 3, set-index bits (8 sets).
- S_TAG, 32-S_OFFSET-S_INDEX, tag width (24).
- S_LINE, 8*2^S_OFFSET, line width in bits (256).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- data_read  in  1  load request; held stable until data_resp.
- data_write  in  1  store request; held stable until data_resp.
- data_mbe  in  4  byte enables for stores; bit i selects data_wdata[8i+7:8i].
- data_addr  in  32  byte address; word selected by addr[4:2].
- data_wdata  in  32  store data, lane-aligned to data_mbe.
- data_resp  out  1  one-cycle completion pulse.
- data_rdata  out  32  full aligned word, valid while data_resp=1.
- pmem_read  out  1  line fill request.
- pmem_write  out  1  line writeback request.
- pmem_address  out  32  line address, low S_OFFSET bits zero.
- pmem_wdata  out  S_LINE  writeback line.
- pmem_rdata  in  S_LINE  fill line, valid with pmem_resp.
- pmem_resp  in  1  one-cycle memory completion.

Behaviour:
- Storage per set: 2 ways × {valid, dirty, tag, line}; 1 LRU bit naming the next victim.
- Index = addr[7:5]; tag = addr[31:8].
- Reset: all valid/dirty/LRU bits cleared; state IDLE; data_resp=0, data_rdata=0, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0. Line contents need not be cleared.
- FSM states: IDLE, LOOKUP, WRITEBACK, FILL.
- IDLE: if data_read|data_write, go to LOOKUP next cycle; no outputs asserted.
- LOOKUP, hit (valid & tag match in way w):
  - data_resp=1 combinationally this cycle.
  - read: data_rdata = word addr[4:2] of way w.
  - write: at the clock edge, bytes with mbe[i]=1 are merged into the word and dirty[w] is set; data_rdata=0.
  - LRU <= ~w; next state IDLE.
  - Hit latency: resp in the 2nd cycle of the request.
- LOOKUP, miss: victim = first invalid way (way0 before way1), else the LRU way. Victim valid & dirty -> WRITEBACK; otherwise -> FILL.
- WRITEBACK:
  - pmem_write=1, pmem_address={victim tag, index, 5'b0}, pmem_wdata=victim line; all held stable.
  - On pmem_resp: clear victim dirty, go to FILL.
- FILL:
  - pmem_read=1, pmem_address={addr tag, index, 5'b0}, held stable.
  - On pmem_resp: victim line <= pmem_rdata, tag written, valid=1, dirty=0; return to LOOKUP, which then hits and completes the access (store merge included).
- data_resp is never asserted outside LOOKUP-hit.
- pmem_read and pmem_write are never both asserted.
- The requester drops its request the cycle after data_resp. IDLE re-samples, so back-to-back requests are separated by at least one idle cycle.
- data_read & data_write both high: illegal, flagged by an assertion; served as a read.
- Request inputs changing mid-miss: illegal, flagged by an assertion.
- rst at any state, including mid-WRITEBACK/FILL: returns to reset state next cycle and drops pmem_* immediately. Dirty data is lost; an outstanding pmem_resp arriving after reset is ignored.
- No flush port: pipeline flushes never abort an in-flight line transaction.

Test Plan:
- Cold read miss: reset; read 0x0000_1004; pmem_rdata word1=0xDEADBEEF -> pmem_read with pmem_address=0x0000_1000, no pmem_write; one cycle after pmem_resp, data_resp=1 with data_rdata=0xDEADBEEF.
- Read hit: read 0x0000_1004 again -> data_resp in cycle 2 with 0xDEADBEEF; pmem_read/pmem_write stay 0 throughout.
- Partial store hit: write 0x0000_1004, mbe=0011, wdata=0x1234ABCD -> data_resp in cycle 2; subsequent read returns 0xDEADABCD.
- Dirty eviction: after the partial store, read 0x0000_1100 (way1 fill), then read 0x0000_1200 -> pmem_write at 0x0000_1000 with pmem_wdata word1=0xDEADABCD, then pmem_read at 0x0000_1200, then data_resp. A following read of 0x0000_1100 hits with no pmem activity.
- Memory stall: delay pmem_resp by 20 cycles during FILL -> pmem_read and pmem_address stable all 20 cycles; data_resp=0 throughout.
- Reset mid-fill: assert rst in the 3rd FILL cycle -> next cycle pmem_read=0, data_resp=0; a later read of 0x0000_1004 misses again.
